memref_rd_arbiter: RTL and testbench
====================================

MEMREF_RD_ARBITER -- requirements
Module: memref_rd_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: read-data width in bits.
REQ-002 Parameter ADDR_WIDTH, default 10: address width (1024-word memref).
REQ-003 Parameter NUM_REQ, default 2, legal range 2..4: number of requesters sharing one memref read port.
REQ-004 Parameter MAX_LOCK, default 16, legal range 1..255: maximum consecutive locked grants to one requester.
REQ-005 clk  input  1  rising-edge clock, the only clock domain.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req_rd_en  input  NUM_REQ  per-requester read request; bit i belongs to requester i.
REQ-008 req_addr_data  input  NUM_REQ*ADDR_WIDTH  per-requester address; slice [i*ADDR_WIDTH +: ADDR_WIDTH] belongs to requester i.
REQ-009 req_lock  input  NUM_REQ  requester asks to keep the port after its current grant (burst).
REQ-010 req_grant  output  NUM_REQ  one-hot-or-zero; requester i's read is issued to memory this cycle.
REQ-011 req_valid  output  NUM_REQ  one-hot-or-zero; req_rd_data carries requester i's data this cycle.
REQ-012 req_rd_data  output  WIDTH  read data broadcast to all requesters.
REQ-013 mem_rd_en  output  1  memref read enable.
REQ-014 mem_addr_data  output  ADDR_WIDTH  memref read address.
REQ-015 mem_rd_data  input  WIDTH  memref read data, valid exactly one cycle after mem_rd_en.

Function
REQ-016 req_grant shall be combinational from current inputs and registered state; at most one bit set per cycle.
REQ-017 A requester whose req_rd_en is high and req_grant is low is stalled, holds its request, and shall be re-arbitrated in the next cycle; the arbiter does not queue requests.
REQ-018 mem_rd_en shall equal OR of req_grant; mem_addr_data shall equal the granted requester's address slice, and all-zeros when no grant.
REQ-019 req_valid shall be req_grant delayed by exactly one cycle; req_rd_data shall equal mem_rd_data combinationally.
REQ-020 Arbitration without an owner: round-robin from priority pointer ptr; the first requester with rd_en high scanning ptr, ptr+1, ... (mod NUM_REQ) is granted.
REQ-021 After an unlocked grant to requester i, ptr shall become (i+1) mod NUM_REQ; with no grant, ptr is unchanged.
REQ-022 Lock state: registers owner_vld, owner_id, lock_cnt (8 bits).
REQ-023 Acquire: a grant to i while req_lock[i] is high sets owner_vld=1, owner_id=i, lock_cnt=1; ptr is not advanced.
REQ-024 Owned cycle: if req_lock[owner_id] is high, only owner_id may be granted (granted iff its rd_en is high); all other requesters stall even when the owner is idle.
REQ-025 Each owned-cycle grant increments lock_cnt; a grant that brings lock_cnt to MAX_LOCK shall clear owner_vld and set ptr=(owner_id+1) mod NUM_REQ (forced release).
REQ-026 Voluntary release: in a cycle where owner_vld=1 and req_lock[owner_id]=0, the owner is ignored and normal round-robin (REQ-020) applies in that same cycle; owner_vld clears at the clock edge.
REQ-027 A requester forcibly released may not re-acquire until one grant to another requester has occurred, or until a cycle occurs in which no other requester has rd_en high.
REQ-028 Simultaneous requests from all NUM_REQ requesters with no lock shall be served in strict rotation, one per cycle, and no requester waits more than NUM_REQ-1 cycles.
REQ-029 Address and data widths pass through unmodified; no arithmetic on addresses.

Reset
REQ-030 While rst is high at a clock edge: ptr=0, owner_vld=0, owner_id=0, lock_cnt=0, req_valid=0, and the forced-release block flag is cleared.
REQ-031 During any cycle in which rst is high, req_grant=0 and mem_rd_en=0, regardless of requests.
REQ-032 Reset asserted mid-burst shall drop the lock; a read granted in the cycle before reset shall not produce req_valid after reset.

Verification
REQ-033 After reset, req_rd_en=2'b11 for 4 cycles, no lock -> req_grant sequence 01,10,01,10; req_valid follows one cycle later; mem_addr_data alternates between the two addresses.
REQ-034 Requester 1 is the only requester, with addr 10'd5 and mem_rd_data=32'hA5A5A5A5 one cycle later -> req_grant=10, req_valid=10 next cycle, req_rd_data=32'hA5A5A5A5.
REQ-035 Requester 0 has lock=1 and rd_en=1 continuously; requester 1 has rd_en=1; MAX_LOCK=4 -> requester 0 is granted 4 consecutive cycles, then requester 1 is granted next, then requester 0.
REQ-036 Requester 0 is locked; it drops lock in cycle k while requester 1 is requesting -> requester 1 is granted in cycle k (same-cycle release).
REQ-037 Owner idles (rd_en=0, lock=1) while requester 1 requests -> req_grant=0 and mem_rd_en=0 in those cycles.
REQ-038 rst pulsed for 1 cycle during a locked burst -> grants are 0 in that cycle, req_valid=0 the next cycle, and arbitration afterwards starts at ptr=0 with no owner.

Source files
------------

// File: rtl/memref_rd_arbiter.sv
// Shares one memref read port among NUM_REQ requesters: round-robin arbitration
// with optional burst locking, a MAX_LOCK cap and a one-cycle read-data return.
module memref_rd_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned MAX_LOCK   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_rd_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_data,
  input  logic [NUM_REQ-1:0]            req_lock,
  output logic [NUM_REQ-1:0]            req_grant,
  output logic [NUM_REQ-1:0]            req_valid,
  output logic [WIDTH-1:0]              req_rd_data,
  output logic                          mem_rd_en,
  output logic [ADDR_WIDTH-1:0]         mem_addr_data,
  input  logic [WIDTH-1:0]              mem_rd_data
);

  localparam int unsigned IDW      = $clog2(NUM_REQ);
  localparam logic [7:0]  LOCK_MAX = 8'(MAX_LOCK);

  typedef enum logic {ARB_FREE, ARB_OWNED} arb_state_e;

  arb_state_e         state, state_nxt;
  logic [IDW-1:0]     ptr, ptr_nxt;
  logic [IDW-1:0]     owner_id, owner_id_nxt;
  logic [7:0]         lock_cnt, lock_cnt_nxt;
  logic               block_vld, block_vld_nxt;
  logic [IDW-1:0]     block_id, block_id_nxt;

  logic               owner_vld;
  logic               owned;
  logic               block_active;
  logic [NUM_REQ-1:0] others;
  logic [NUM_REQ-1:0] eligible;
  logic               gnt_any;
  logic [IDW-1:0]     gnt_id;

  function automatic logic [IDW-1:0] inc_idx(input logic [IDW-1:0] i);
    return (32'(i) == NUM_REQ - 1) ? '0 : IDW'(32'(i) + 32'd1);
  endfunction

  // Grant selection: owner-only while locked, otherwise round-robin from ptr.
  // A voluntarily releasing owner and a blocked (force-released) requester sit out.
  always_comb begin
    owner_vld    = (state == ARB_OWNED);
    owned        = owner_vld && req_lock[owner_id];
    others       = req_rd_en;
    others[block_id] = 1'b0;
    block_active = block_vld && (|others);
    eligible     = req_rd_en;
    if (block_active) eligible[block_id] = 1'b0;
    if (owner_vld) eligible[owner_id] = 1'b0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    if (!rst) begin
      if (owned) begin
        gnt_any = req_rd_en[owner_id];
        gnt_id  = owner_id;
      end else begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          if (!gnt_any && eligible[IDW'((32'(ptr) + k) % NUM_REQ)]) begin
            gnt_any = 1'b1;
            gnt_id  = IDW'((32'(ptr) + k) % NUM_REQ);
          end
        end
      end
    end
  end

  assign req_grant     = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;
  assign mem_rd_en     = gnt_any;
  assign mem_addr_data = gnt_any ? req_addr_data[gnt_id*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign req_rd_data   = mem_rd_data;

  // Next-state: lock acquire/count/release, pointer advance, re-acquire block.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    owner_id_nxt  = owner_id;
    lock_cnt_nxt  = lock_cnt;
    block_vld_nxt = block_vld;
    block_id_nxt  = block_id;

    if (block_vld && (!block_active || (gnt_any && (gnt_id != block_id)))) begin
      block_vld_nxt = 1'b0;
    end

    if (owned) begin
      if (gnt_any) begin
        if ((lock_cnt + 8'd1) == LOCK_MAX) begin
          state_nxt     = ARB_FREE;
          lock_cnt_nxt  = '0;
          ptr_nxt       = inc_idx(owner_id);
          block_vld_nxt = 1'b1;
          block_id_nxt  = owner_id;
        end else begin
          lock_cnt_nxt = lock_cnt + 8'd1;
        end
      end
    end else begin
      state_nxt    = ARB_FREE;
      lock_cnt_nxt = '0;
      if (gnt_any) begin
        if (!req_lock[gnt_id]) begin
          ptr_nxt = inc_idx(gnt_id);
        end else if (LOCK_MAX == 8'd1) begin
          // a single-grant cap releases on the acquiring grant itself
          ptr_nxt       = inc_idx(gnt_id);
          block_vld_nxt = 1'b1;
          block_id_nxt  = gnt_id;
        end else begin
          state_nxt    = ARB_OWNED;
          owner_id_nxt = gnt_id;
          lock_cnt_nxt = 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_FREE;
      ptr       <= '0;
      owner_id  <= '0;
      lock_cnt  <= '0;
      block_vld <= 1'b0;
      block_id  <= '0;
      req_valid <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      owner_id  <= owner_id_nxt;
      lock_cnt  <= lock_cnt_nxt;
      block_vld <= block_vld_nxt;
      block_id  <= block_id_nxt;
      req_valid <= req_grant;
    end
  end

endmodule

// File: tb/tb_memref_rd_arbiter.sv
// Bench for memref_rd_arbiter: directed scenarios plus random traffic, all
// checked against an integer-level model of the arbitration rules.
module tb_memref_rd_arbiter;

  localparam int WIDTH = 32;
  localparam int AW    = 10;
  localparam int N     = 2;
  localparam int MAXL  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_rd_en;
  logic [N*AW-1:0]   req_addr_data;
  logic [N-1:0]      req_lock;
  logic [N-1:0]      req_grant;
  logic [N-1:0]      req_valid;
  logic [WIDTH-1:0]  req_rd_data;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_addr_data;
  logic [WIDTH-1:0]  mem_rd_data;

  always #5 clk = ~clk;

  memref_rd_arbiter #(
    .WIDTH(WIDTH), .ADDR_WIDTH(AW), .NUM_REQ(N), .MAX_LOCK(MAXL)
  ) dut (
    .clk(clk), .rst(rst),
    .req_rd_en(req_rd_en), .req_addr_data(req_addr_data), .req_lock(req_lock),
    .req_grant(req_grant), .req_valid(req_valid), .req_rd_data(req_rd_data),
    .mem_rd_en(mem_rd_en), .mem_addr_data(mem_addr_data), .mem_rd_data(mem_rd_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [1024];

  // model state: -1 means "none"
  int         m_ptr, m_owner, m_cnt, m_block, m_prev_g, m_g;
  logic       m_others, m_r;
  logic [9:0] m_prev_addr;
  int         m_en [N];
  int         m_lk [N];
  logic [9:0] m_addr [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_eval();
    int j;
    m_others = 1'b0;
    for (int i = 0; i < N; i++) if (i != m_block && m_en[i] != 0) m_others = 1'b1;
    m_g = -1;
    if (!m_r) begin
      if (m_owner >= 0 && m_lk[m_owner] != 0) begin
        if (m_en[m_owner] != 0) m_g = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (m_g < 0 && m_en[j] != 0 && j != m_owner && !(j == m_block && m_others))
            m_g = j;
        end
      end
    end
  endtask

  task automatic model_update();
    if (m_r) begin
      m_ptr = 0; m_owner = -1; m_cnt = 0; m_block = -1; m_prev_g = -1;
    end else begin
      if (m_block >= 0 && (!m_others || (m_g >= 0 && m_g != m_block))) m_block = -1;
      if (m_owner >= 0 && m_lk[m_owner] != 0) begin
        if (m_g >= 0) begin
          m_cnt++;
          if (m_cnt >= MAXL) begin
            m_block = m_owner;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
          end
        end
      end else begin
        m_owner = -1;
        if (m_g >= 0) begin
          if (m_lk[m_g] != 0) begin
            m_owner = m_g;
            m_cnt   = 1;
          end else begin
            m_ptr = (m_g + 1) % N;
          end
        end
      end
      m_prev_g = m_g;
      if (m_g >= 0) m_prev_addr = m_addr[m_g];
    end
  endtask

  // Drive one cycle's inputs, then compare every output against the model mid-cycle.
  task automatic apply_in(input logic r, input logic [1:0] en, input logic [1:0] lk,
                          input logic [9:0] a0, input logic [9:0] a1);
    logic [31:0] exp_data;
    logic [1:0]  exp_gnt, exp_vld;
    logic [9:0]  exp_addr;
    rst           = r;
    req_rd_en     = en;
    req_lock      = lk;
    req_addr_data = {a1, a0};
    exp_data      = (m_prev_g >= 0) ? mem[m_prev_addr] : $urandom;
    mem_rd_data   = exp_data;
    m_r = r;
    m_en[0] = int'(en[0]); m_en[1] = int'(en[1]);
    m_lk[0] = int'(lk[0]); m_lk[1] = int'(lk[1]);
    m_addr[0] = a0; m_addr[1] = a1;
    model_eval();
    #4;
    exp_gnt  = (m_g >= 0) ? 2'(1 << m_g) : 2'b00;
    exp_vld  = (m_prev_g >= 0) ? 2'(1 << m_prev_g) : 2'b00;
    exp_addr = (m_g >= 0) ? m_addr[m_g] : 10'd0;
    chk("grant",     32'(req_grant),     32'(exp_gnt));
    chk("mem_rd_en", 32'(mem_rd_en),     32'(m_g >= 0));
    chk("mem_addr",  32'(mem_addr_data), 32'(exp_addr));
    chk("valid",     32'(req_valid),     32'(exp_vld));
    chk("rd_data",   req_rd_data,        exp_data);
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    apply_in(1'b1, 2'b11, 2'b01, 10'h155, 10'h2aa);
    chk("rst_gnt_zero", 32'(req_grant), 32'd0);
    step();
  endtask

  logic [1:0] rr_seq   [4];
  logic [9:0] rr_addr  [4];
  logic [1:0] lock_seq [7];
  logic [1:0] rlk, ren;

  initial begin
    rst = 1'b1; req_rd_en = '0; req_lock = '0; req_addr_data = '0; mem_rd_data = '0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[5] = 32'hA5A5A5A5;
    m_ptr = 0; m_owner = -1; m_cnt = 0; m_block = -1; m_prev_g = -1; m_g = -1;
    m_prev_addr = '0; m_r = 1'b1; m_others = 1'b0;
    rr_seq   = '{2'b01, 2'b10, 2'b01, 2'b10};
    rr_addr  = '{10'h011, 10'h022, 10'h011, 10'h022};
    lock_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
    @(posedge clk);
    #1;

    // both requesting, no lock: strict alternation
    do_rst();
    for (int i = 0; i < 4; i++) begin
      apply_in(1'b0, 2'b11, 2'b00, 10'h011, 10'h022);
      chk("rr_seq", 32'(req_grant), 32'(rr_seq[i]));
      chk("rr_addr", 32'(mem_addr_data), 32'(rr_addr[i]));
      step();
    end

    // lone requester 1 read and data return
    do_rst();
    apply_in(1'b0, 2'b10, 2'b00, 10'h3ff, 10'd5);
    chk("solo_gnt", 32'(req_grant), 32'h2);
    chk("solo_addr", 32'(mem_addr_data), 32'd5);
    step();
    apply_in(1'b0, 2'b00, 2'b00, 10'd0, 10'd0);
    chk("solo_vld", 32'(req_valid), 32'h2);
    chk("solo_data", req_rd_data, 32'hA5A5A5A5);
    step();

    // locked burst capped at MAX_LOCK, then forced handover
    do_rst();
    for (int i = 0; i < 7; i++) begin
      apply_in(1'b0, 2'b11, 2'b01, 10'h0a0, 10'h0b0);
      chk("lock_seq", 32'(req_grant), 32'(lock_seq[i]));
      step();
    end

    // voluntary release hands over in the same cycle
    do_rst();
    for (int i = 0; i < 2; i++) begin
      apply_in(1'b0, 2'b11, 2'b01, 10'h0c0, 10'h0d0);
      chk("vrel_own", 32'(req_grant), 32'h1);
      step();
    end
    apply_in(1'b0, 2'b11, 2'b00, 10'h0c0, 10'h0d0);
    chk("vrel_hand", 32'(req_grant), 32'h2);
    step();

    // idle owner stalls everyone else
    do_rst();
    apply_in(1'b0, 2'b01, 2'b01, 10'h010, 10'h020);
    chk("idle_acq", 32'(req_grant), 32'h1);
    step();
    for (int i = 0; i < 2; i++) begin
      apply_in(1'b0, 2'b10, 2'b01, 10'h010, 10'h020);
      chk("idle_gnt", 32'(req_grant), 32'h0);
      chk("idle_men", 32'(mem_rd_en), 32'h0);
      step();
    end

    // reset pulse mid-burst drops the lock and the in-flight valid
    do_rst();
    for (int i = 0; i < 2; i++) begin
      apply_in(1'b0, 2'b11, 2'b01, 10'h111, 10'h222);
      step();
    end
    apply_in(1'b1, 2'b11, 2'b01, 10'h111, 10'h222);
    chk("rstb_gnt", 32'(req_grant), 32'h0);
    step();
    apply_in(1'b0, 2'b11, 2'b00, 10'h111, 10'h222);
    chk("rstb_vld", 32'(req_valid), 32'h0);
    chk("rstb_gnt0", 32'(req_grant), 32'h1);
    step();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      ren = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
      rlk = {1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7)};
      apply_in(1'($urandom_range(0, 63) == 0), ren, rlk, 10'($urandom), 10'($urandom));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
